// File: rtl/alu_cmd_issuer.sv
// Command FIFO feeding a fixed-latency ALU; issues one command at a time,
// waits ALU_LAT cycles, and holds the captured result until the consumer takes it.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  input  logic [3:0]               cmd_s,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [3:0]               alu_s,
  input  logic [15:0]              alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_data,
  output logic [3:0]               rsp_s,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = 2;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t          state;
  cmd_t            mem [DEPTH];
  cmd_t            head_c;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   wait_cnt;
  logic            push_c;
  logic            pop_c;
  logic [CW-1:0]   count_nxt_c;

  assign head_c = mem[rd_ptr];
  assign push_c = cmd_valid && cmd_ready;
  // Only an idle issuer pops; a full FIFO never accepts on the freeing edge.
  assign pop_c  = (state == IDLE) && (count != '0);

  always_comb begin
    count_nxt_c = count + CW'(push_c) - CW'(pop_c);
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt_c;
      cmd_ready <= (count_nxt_c < CW'(DEPTH));
    end
  end

  // Issue / wait / hold sequencer with registered ALU and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_s     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_c) begin
            alu_a    <= head_c.a;
            alu_b    <= head_c.b;
            alu_s    <= head_c.s;
            rsp_s    <= head_c.s;
            wait_cnt <= LW'(ALU_LAT);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == LW'(1)) begin
            rsp_data  <= alu_out;
            rsp_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - LW'(1);
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: one instance at ALU_LAT=1, one at ALU_LAT=3,
// each driven by a behavioural ALU whose result is only valid after the stated latency.
module tb_alu_cmd_issuer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid_1, cmd_ready_1, rsp_valid_1, rsp_ready_1;
  logic [7:0]  cmd_a_1, cmd_b_1, alu_a_1, alu_b_1;
  logic [3:0]  cmd_s_1, alu_s_1, rsp_s_1;
  logic [15:0] alu_out_1, rsp_data_1;
  logic [2:0]  count_1;

  logic        cmd_valid_3, cmd_ready_3, rsp_valid_3, rsp_ready_3;
  logic [7:0]  cmd_a_3, cmd_b_3, alu_a_3, alu_b_3;
  logic [3:0]  cmd_s_3, alu_s_3, rsp_s_3;
  logic [15:0] alu_out_3, rsp_data_3;
  logic [2:0]  count_3;

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s);
    case (s)
      4'h0:    return 16'(a) + 16'(b);
      4'h1:    return 16'(a) - 16'(b);
      4'h2:    return 16'(a) * 16'(b);
      default: return {a, b};
    endcase
  endfunction

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
    .cmd_a(cmd_a_1), .cmd_b(cmd_b_1), .cmd_s(cmd_s_1),
    .alu_a(alu_a_1), .alu_b(alu_b_1), .alu_s(alu_s_1), .alu_out(alu_out_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_data(rsp_data_1),
    .rsp_s(rsp_s_1), .count(count_1)
  );

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
    .cmd_a(cmd_a_3), .cmd_b(cmd_b_3), .cmd_s(cmd_s_3),
    .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_s(alu_s_3), .alu_out(alu_out_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_data(rsp_data_3),
    .rsp_s(rsp_s_3), .count(count_3)
  );

  // Latency-1 ALU is combinational; latency-3 ALU is a two-stage pipe so an early sample is stale.
  always_comb alu_out_1 = alu_f(alu_a_1, alu_b_1, alu_s_1);

  logic [15:0] pipe0_3, pipe1_3;
  always @(posedge clk) begin
    pipe0_3 <= alu_f(alu_a_3, alu_b_3, alu_s_3);
    pipe1_3 <= pipe0_3;
  end
  assign alu_out_3 = pipe1_3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid_1(output logic ok);
    for (int c = 0; c < 20 && !rsp_valid_1; c++) @(negedge clk);
    ok = rsp_valid_1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  s;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [19:0] expq [$];
  logic [19:0] c;
  logic        ok;
  int          n, last;
  logic        stale;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h0F, 8'h03, 4'h0, 16'h0012};
    vecs[1] = '{8'hFF, 8'h01, 4'h0, 16'h0100};
    vecs[2] = '{8'h10, 8'h20, 4'h1, 16'hFFF0};
    vecs[3] = '{8'hFF, 8'hFF, 4'h2, 16'hFE01};
    vecs[4] = '{8'h12, 8'h34, 4'h5, 16'h1234};
    vecs[5] = '{8'h00, 8'h00, 4'h0, 16'h0000};

    cmd_valid_1 = 0; cmd_a_1 = 0; cmd_b_1 = 0; cmd_s_1 = 0; rsp_ready_1 = 1;
    cmd_valid_3 = 0; cmd_a_3 = 0; cmd_b_3 = 0; cmd_s_3 = 0; rsp_ready_3 = 1;
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready_1), 32'd1);
    chk("rst_count",     32'(count_1),     32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_1), 32'd0);
    chk("rst_alu",       32'({alu_a_1, alu_b_1, alu_s_1}), 32'd0);
    chk("rst_rsp",       32'({rsp_data_1, rsp_s_1}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // Single commands with rsp_ready high: issue one edge after push, result one edge later.
    foreach (vecs[i]) begin
      @(negedge clk);
      cmd_valid_1 = 1; cmd_a_1 = vecs[i].a; cmd_b_1 = vecs[i].b; cmd_s_1 = vecs[i].s;
      @(negedge clk);
      cmd_valid_1 = 0;
      chk("vec_no_bypass_count", 32'(count_1), 32'd1);
      chk("vec_no_bypass_valid", 32'(rsp_valid_1), 32'd0);
      @(negedge clk);
      chk("vec_alu_a", 32'(alu_a_1), 32'(vecs[i].a));
      chk("vec_alu_b", 32'(alu_b_1), 32'(vecs[i].b));
      chk("vec_alu_s", 32'(alu_s_1), 32'(vecs[i].s));
      chk("vec_wait_valid", 32'(rsp_valid_1), 32'd0);
      @(negedge clk);
      chk("vec_rsp_valid", 32'(rsp_valid_1), 32'd1);
      chk("vec_rsp_data",  32'(rsp_data_1),  32'(vecs[i].exp));
      chk("vec_rsp_s",     32'(rsp_s_1),     32'(vecs[i].s));
      @(negedge clk);
      chk("vec_rsp_clear", 32'(rsp_valid_1), 32'd0);
    end

    // Fill under back-pressure: 6 pushes attempted, first issued and held, four queued, sixth refused.
    rsp_ready_1 = 0;
    expq.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("fill_count_full", 32'(count_1), 32'd4);
        chk("fill_ready_low",  32'(cmd_ready_1), 32'd0);
      end
      c = {8'(8'h30 + i), 8'(8'h05 + i), 4'(i % 3)};
      if (i < 5) expq.push_back(c);
      cmd_valid_1 = 1; cmd_a_1 = c[19:12]; cmd_b_1 = c[11:4]; cmd_s_1 = c[3:0];
    end
    @(negedge clk);
    cmd_valid_1 = 0;
    chk("fill_count_after_refuse", 32'(count_1), 32'd4);
    chk("fill_ready_after_refuse", 32'(cmd_ready_1), 32'd0);
    chk("fill_hold_valid", 32'(rsp_valid_1), 32'd1);
    chk("fill_hold_data",  32'(rsp_data_1), 32'(alu_f(8'h30, 8'h05, 4'h0)));
    @(negedge clk);
    chk("fill_hold_stable", 32'({rsp_valid_1, rsp_data_1, rsp_s_1}),
        32'({1'b1, alu_f(8'h30, 8'h05, 4'h0), 4'h0}));

    // Release: drain in push order, one result every 3 cycles.
    rsp_ready_1 = 1;
    n = 0; last = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (rsp_valid_1) begin
        if (expq.size() > 0) c = expq.pop_front();
        else c = '1;
        chk("drain_data", 32'(rsp_data_1), 32'(alu_f(c[19:12], c[11:4], c[3:0])));
        chk("drain_s",    32'(rsp_s_1),    32'(c[3:0]));
        if (n > 0) chk("drain_interval", 32'(cyc - last), 32'd3);
        last = cyc;
        n++;
      end
      @(negedge clk);
    end
    chk("drain_resp_count", 32'(n), 32'd5);
    chk("drain_count_zero", 32'(count_1), 32'd0);
    chk("drain_ready_high", 32'(cmd_ready_1), 32'd1);

    // Simultaneous push and pop at count=2, six times, crossing pointer wrap.
    rsp_ready_1 = 0;
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      c = {8'(8'hA0 + i), 8'(8'h11 * (i + 1)), 4'(i)};
      expq.push_back(c);
      cmd_valid_1 = 1; cmd_a_1 = c[19:12]; cmd_b_1 = c[11:4]; cmd_s_1 = c[3:0];
    end
    @(negedge clk);
    cmd_valid_1 = 0;
    chk("pp_count_start", 32'(count_1), 32'd2);
    rsp_ready_1 = 1;
    for (int j = 0; j < 6; j++) begin
      wait_valid_1(ok);
      chk("pp_rsp_timeout", 32'(ok), 32'd1);
      c = expq.pop_front();
      chk("pp_rsp_data", 32'(rsp_data_1), 32'(alu_f(c[19:12], c[11:4], c[3:0])));
      @(negedge clk);
      c = {8'(8'h50 + j), 8'(8'h07 * (j + 1)), 4'(j % 3)};
      expq.push_back(c);
      cmd_valid_1 = 1; cmd_a_1 = c[19:12]; cmd_b_1 = c[11:4]; cmd_s_1 = c[3:0];
      @(negedge clk);
      cmd_valid_1 = 0;
      chk("pp_count_stays", 32'(count_1), 32'd2);
    end
    for (int j = 0; j < 3; j++) begin
      wait_valid_1(ok);
      chk("pp_tail_timeout", 32'(ok), 32'd1);
      c = expq.pop_front();
      chk("pp_tail_data", 32'(rsp_data_1), 32'(alu_f(c[19:12], c[11:4], c[3:0])));
      chk("pp_tail_s",    32'(rsp_s_1),    32'(c[3:0]));
      @(negedge clk);
    end
    chk("pp_count_end", 32'(count_1), 32'd0);

    // ALU_LAT=3: capture exactly three edges after issue, ALU inputs steady meanwhile.
    @(negedge clk);
    cmd_valid_3 = 1; cmd_a_3 = 8'hFF; cmd_b_3 = 8'hFF; cmd_s_3 = 4'h2;
    @(negedge clk);
    cmd_valid_3 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lat3_alu", 32'({alu_a_3, alu_b_3, alu_s_3}), 32'({8'hFF, 8'hFF, 4'h2}));
      chk("lat3_wait_valid", 32'(rsp_valid_3), 32'd0);
    end
    @(negedge clk);
    chk("lat3_valid", 32'(rsp_valid_3), 32'd1);
    chk("lat3_data",  32'(rsp_data_3),  32'h0000FE01);
    chk("lat3_s",     32'(rsp_s_3),     32'd2);
    @(negedge clk);
    chk("lat3_clear", 32'(rsp_valid_3), 32'd0);

    // Reset in WAIT with two queued commands: everything cleared without a clock edge.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid_3 = 1; cmd_a_3 = 8'(8'h21 + i); cmd_b_3 = 8'(8'h43 + i); cmd_s_3 = 4'h0;
    end
    @(negedge clk);
    cmd_valid_3 = 0;
    chk("rstw_pre_count", 32'(count_3), 32'd2);
    chk("rstw_pre_alu_a", 32'(alu_a_3), 32'h21);
    #2 rst_n = 0;
    #1;
    chk("rstw_valid",   32'(rsp_valid_3), 32'd0);
    chk("rstw_count",   32'(count_3),     32'd0);
    chk("rstw_alu",     32'({alu_a_3, alu_b_3, alu_s_3}), 32'd0);
    chk("rstw_rsp",     32'({rsp_data_3, rsp_s_3}), 32'd0);
    chk("rstw_ready",   32'(cmd_ready_3), 32'd1);
    @(negedge clk);
    rst_n = 1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid_3 || count_3 != 3'd0 || alu_a_3 != 8'h00) stale = 1;
    end
    chk("rstw_no_stale", 32'(stale), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
